// File: rtl/level_sensor_filter_pkg.sv
// Shared definitions for the level sensor conditioning stage.
//   fault_state_e   : fault FSM encodings, shared with the tank controller
//   SAFE_LVL        : sensor level forced while a fault is latched (reads FULL)
//   is_implausible  : lower dry while upper wet, which cannot happen physically
package level_sensor_filter_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAULT   = 2'b10
    } fault_state_e;

    localparam logic SAFE_LVL = 1'b1;

    function automatic logic is_implausible(input logic lvl_i, input logic lvl_s);
        return !lvl_i && lvl_s;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One float-switch channel: 2-flop synchroniser followed by a debouncer.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low reset
//   d_raw  in  raw switch level, asynchronous to clk
//   q      out debounced level; follows the synchronised input only after it
//              has differed for DEBOUNCE_CYCLES consecutive cycles
import level_sensor_filter_pkg::*;

module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic d_raw,
    output logic q
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The second flop resolves metastability from the first; nothing may sit between them.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= SAFE_LVL;
            sync2_q <= SAFE_LVL;
        end else begin
            sync1_q <= d_raw;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synchronised input agrees with the stable level
    // restarts the count, so only an unbroken run of disagreement flips q.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q <= SAFE_LVL;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign q = lvl_q;

endmodule

// File: rtl/level_sensor_filter.sv
// Conditioning stage in front of the tank pump controller.
//   clk          in  system clock, rising edge
//   reset        in  asynchronous, active-low reset
//   I_raw        in  raw lower float switch
//   S_raw        in  raw upper float switch
//   clear_fault  in  single-cycle request to clear a latched fault
//   I            out filtered lower level (forced to SAFE_LVL in fault)
//   S            out filtered upper level (forced to SAFE_LVL in fault)
//   fault        out implausible pair (I=0,S=1) latched
//   valid        out startup settle window complete
import level_sensor_filter_pkg::*;

module level_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic I_raw,
    input  logic S_raw,
    input  logic clear_fault,
    output logic I,
    output logic S,
    output logic fault,
    output logic valid
);

    // fcnt is 1 on entry to SUSPECT, so it must be able to hold 1 even when FAULT_CYCLES==1.
    localparam int                FCNT_W    = $clog2(FAULT_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FAULT_CYCLES - 1);
    localparam int                SCNT_W    = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(DEBOUNCE_CYCLES + 1);

    logic              q_i, q_s, impl;
    fault_state_e      state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              fault_q;
    logic [SCNT_W-1:0] start_cnt_q;
    logic              valid_q;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_i (
        .clk   (clk),
        .reset (reset),
        .d_raw (I_raw),
        .q     (q_i)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
        .clk   (clk),
        .reset (reset),
        .d_raw (S_raw),
        .q     (q_s)
    );

    assign impl = is_implausible(q_i, q_s);

    // fcnt counts consecutive implausible samples including the one that
    // entered SUSPECT; the ">=" lets FAULT_CYCLES==1 still reach FAULT one
    // edge after SUSPECT.
    always_comb begin
        state_d = state_q;
        fcnt_d  = '0;
        unique case (state_q)
            ST_OK: begin
                if (impl) begin
                    state_d = ST_SUSPECT;
                    fcnt_d  = FCNT_W'(1);
                end
            end
            ST_SUSPECT: begin
                if (!impl) begin
                    state_d = ST_OK;
                end else if (fcnt_q >= FCNT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
            ST_FAULT: begin
                // A clear is only honoured once the sensors read plausibly again.
                if (clear_fault && !impl) begin
                    state_d = ST_OK;
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OK;
            fcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            // Loaded from the next state so the flag lands on the same edge as FAULT.
            fault_q <= (state_d == ST_FAULT);
        end
    end

    // valid marks the end of the first full debounce latency after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else if (!valid_q) begin
            if (start_cnt_q == SCNT_LAST) begin
                valid_q <= 1'b1;
            end else begin
                start_cnt_q <= start_cnt_q + SCNT_W'(1);
            end
        end
    end

    // Levels come straight from the debounce flops and the fault flag is a
    // flop, so these outputs change only on clock or reset edges. In SUSPECT
    // the implausible pair is passed through; the controller idles pumps on it.
    assign I     = fault_q ? SAFE_LVL : q_i;
    assign S     = fault_q ? SAFE_LVL : q_s;
    assign fault = fault_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_level_sensor_filter.sv
// Directed bench for level_sensor_filter with DEBOUNCE_CYCLES=4, FAULT_CYCLES=8.
// Inputs change 1 time unit after a rising edge; "edge k" is the k-th rising
// edge after that change. Outputs are sampled 1 time unit after each edge and
// compared as the vector {I, S, fault, valid}.
module tb_level_sensor_filter;

    localparam int DEB = 4;
    localparam int FLT = 8;

    logic clk = 1'b0;
    logic reset, I_raw, S_raw, clear_fault;
    logic I, S, fault, valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    level_sensor_filter #(
        .DEBOUNCE_CYCLES (DEB),
        .FAULT_CYCLES    (FLT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .I_raw       (I_raw),
        .S_raw       (S_raw),
        .clear_fault (clear_fault),
        .I           (I),
        .S           (S),
        .fault       (fault),
        .valid       (valid)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: {I,S,fault,valid} got %b expected %b", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        I_raw       = 1'b1;
        S_raw       = 1'b1;
        clear_fault = 1'b0;

        // 1: reset state, then valid rises on edge 6 after release.
        #2 reset = 1'b0;
        #2 check("reset_async", {I, S, fault, valid}, 4'b1100);
        step();
        step();
        check("reset_held", {I, S, fault, valid}, 4'b1100);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("startup k=%0d", k), {I, S, fault, valid}, {3'b110, (k >= DEB + 2)});
        end

        // 2: I falls on edge 6; restored before the fault window can expire.
        I_raw = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("i_fall k=%0d", k), {I, S, fault, valid}, {(k < 6), 3'b101});
        end
        I_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("i_rise k=%0d", k), {I, S, fault, valid}, {(k >= 6), 3'b101});
        end

        // 2: a 3-cycle low glitch is rejected.
        I_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) I_raw = 1'b1;
            check($sformatf("glitch k=%0d", k), {I, S, fault, valid}, 4'b1101);
        end

        // 3: 5-cycle implausible window does not latch a fault.
        I_raw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 5) I_raw = 1'b1;
            check($sformatf("short_impl k=%0d", k), {I, S, fault, valid},
                  {!(k >= 6 && k <= 10), 3'b101});
        end

        // 3: held implausible pair: SUSPECT entered on edge 7, FAULT on edge 14.
        I_raw = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k >= 14)
                check($sformatf("fault k=%0d", k), {I, S, fault, valid}, 4'b1111);
            else
                check($sformatf("fault k=%0d", k), {I, S, fault, valid}, {(k < 6), 3'b101});
        end

        // 4: clear while still implausible is ignored.
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("clear_ignored", {I, S, fault, valid}, 4'b1111);
        step();
        check("clear_ignored_hold", {I, S, fault, valid}, 4'b1111);

        // 4: restore I, fault stays latched until cleared.
        I_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("fault_hold k=%0d", k), {I, S, fault, valid}, 4'b1111);
        end
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
        check("clear_ok", {I, S, fault, valid}, 4'b1101);
        step();
        check("clear_ok_hold", {I, S, fault, valid}, 4'b1101);

        // 5: reset in SUSPECT while I is mid-debounce.
        I_raw = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        check("pre_rst_suspect", {I, S, fault, valid}, 4'b0101);
        I_raw = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        check("pre_rst_debounce", {I, S, fault, valid}, 4'b0101);
        #2 reset = 1'b0;
        #1 check("mid_reset_async", {I, S, fault, valid}, 4'b1100);
        step();
        check("mid_reset_held", {I, S, fault, valid}, 4'b1100);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("restart k=%0d", k), {I, S, fault, valid}, {3'b110, (k >= DEB + 2)});
        end

        // 6: both channels fall together on edge 6, no fault.
        I_raw = 1'b0;
        S_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("both_fall k=%0d", k), {I, S, fault, valid}, {(k < 6), (k < 6), 2'b01});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
